// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the GCM-AES core.
//   - Byte and block sizes.
//   - Affine transform constants (forward and inverse).
//   - SubBytes folding FSM state type.
//   - GF(2^8) helpers (reduction polynomial x^8+x^4+x^3+x+1).
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int NB_BYTE       = 8;
    localparam int N_BYTES_BLOCK = 16;

    localparam logic [7:0] AES_AFFINE_C     = 8'h63;
    localparam logic [7:0] AES_INV_AFFINE_C = 8'h05;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sub_bytes_state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // a^-1 = a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// File: rtl/multiplicative_inversion.sv
// ----------------------------------------------------------------------------
// multiplicative_inversion
// Pipelined GF(2^8) inversion lane. Input register plus result register give
// a 2-cycle latency; OUTPUT_REG adds a third stage. inv(0x00) = 0x00.
// Ports:
//   i_clock  in   1  clock
//   i_reset  in   1  synchronous active-high reset (clears in-flight valids)
//   i_valid  in   1  input byte valid
//   i_data   in   8  byte to invert
//   o_valid  out  1  result valid
//   o_data   out  8  multiplicative inverse of i_data
// ----------------------------------------------------------------------------
module multiplicative_inversion
    import aes_pkg::*;
#(
    parameter bit OUTPUT_REG = 1'b0
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_valid,
    output logic [7:0] o_data
);

    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s2_valid;
    logic [7:0] s2_data;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s1_valid <= i_valid;
            s1_data  <= i_data;
            s2_valid <= s1_valid;
            s2_data  <= gf_inv(s1_data);
        end
    end

    generate
        if (OUTPUT_REG) begin : g_out_reg
            logic       s3_valid;
            logic [7:0] s3_data;
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    s3_valid <= 1'b0;
                    s3_data  <= '0;
                end else begin
                    s3_valid <= s2_valid;
                    s3_data  <= s2_data;
                end
            end
            assign o_valid = s3_valid;
            assign o_data  = s3_data;
        end else begin : g_no_out_reg
            assign o_valid = s2_valid;
            assign o_data  = s2_data;
        end
    endgenerate

endmodule

// File: rtl/sbox_affine_transform.sv
// ----------------------------------------------------------------------------
// sbox_affine_transform
// Combinational AES S-box affine map on one byte.
//   INVERSE = 0 : s_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ 0x63_i
//   INVERSE = 1 : b_i = a_(i+2) ^ a_(i+5) ^ a_(i+7) ^ 0x05_i
//   (indices mod 8)
// Ports:
//   i_byte  in   8  byte to transform
//   o_byte  out  8  transformed byte
// ----------------------------------------------------------------------------
module sbox_affine_transform
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    always_comb begin
        o_byte = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (INVERSE) begin
                o_byte[i] = i_byte[(i + 2) % 8] ^ i_byte[(i + 5) % 8]
                          ^ i_byte[(i + 7) % 8] ^ AES_INV_AFFINE_C[i];
            end else begin
                o_byte[i] = i_byte[i]           ^ i_byte[(i + 4) % 8]
                          ^ i_byte[(i + 5) % 8] ^ i_byte[(i + 6) % 8]
                          ^ i_byte[(i + 7) % 8] ^ AES_AFFINE_C[i];
            end
        end
    end

endmodule

// File: rtl/aes_sub_bytes_folded.sv
// ----------------------------------------------------------------------------
// aes_sub_bytes_folded
// Folded AES SubBytes: a registered 128-bit state is streamed one slice of
// N_SBOX bytes per cycle through N_SBOX GF(2^8) inversion lanes; returned
// bytes pass through the forward affine map and are reassembled in o_state.
// Byte b of a state is bits [8b+7:8b]; lane j carries byte k*N_SBOX+j of
// slice k.
// Optional feature (macro AES_SUB_BYTES_INV_EN): adds i_inv; when set on
// accept, bytes get the inverse affine before inversion and the forward affine
// is bypassed on return (InvSubBytes).
// Ports:
//   i_clock  in   1     clock
//   i_reset  in   1     synchronous active-high reset
//   i_state  in   128   input state
//   i_valid  in   1     input state valid
//   i_inv    in   1     inverse select (AES_SUB_BYTES_INV_EN only)
//   o_ready  out  1     block can accept a state (IDLE only)
//   o_state  out  128   substituted state
//   o_valid  out  1     o_state valid
//   i_ready  in   1     downstream accepts o_state
// ----------------------------------------------------------------------------
module aes_sub_bytes_folded
    import aes_pkg::*;
#(
    parameter int NB_BYTE     = 8,
    parameter int N_BYTES     = N_BYTES_BLOCK,
    parameter int N_SBOX      = 4,
    parameter int INV_LATENCY = 2
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NB_BYTE*N_BYTES-1:0] i_state,
    input  logic                       i_valid,
`ifdef AES_SUB_BYTES_INV_EN
    input  logic                       i_inv,
`endif
    output logic                       o_ready,
    output logic [NB_BYTE*N_BYTES-1:0] o_state,
    output logic                       o_valid,
    input  logic                       i_ready
);

    localparam int N_SLICES = N_BYTES / N_SBOX;
    localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N_SLICES - 1);

    // Packed slice/lane/byte view; flattens to the same bit order as i_state.
    typedef logic [N_SLICES-1:0][N_SBOX-1:0][NB_BYTE-1:0] state_arr_t;

    sub_bytes_state_t state_q;
    sub_bytes_state_t state_d;

    state_arr_t       in_q;
    state_arr_t       out_q;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic             accept;
    logic             lane_issue;
    logic             ret_valid;
    logic [N_SBOX-1:0] lane_valid;
    logic [N_SBOX-1:0][NB_BYTE-1:0] ret_bytes;

`ifdef AES_SUB_BYTES_INV_EN
    logic inv_q;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        lane_issue = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lane_issue = 1'b1;
                if (issue_cnt == LAST_SLICE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_valid && (ret_cnt == LAST_SLICE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            in_q      <= '0;
            out_q     <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
`ifdef AES_SUB_BYTES_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                in_q      <= i_state;
                issue_cnt <= '0;
                ret_cnt   <= '0;
`ifdef AES_SUB_BYTES_INV_EN
                inv_q     <= i_inv;
`endif
            end
            if (lane_issue) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (ret_valid) begin
                out_q[ret_cnt] <= ret_bytes;
                ret_cnt        <= ret_cnt + 1'b1;
            end
        end
    end

    // All lanes are fed and reset together, so their valids are identical;
    // reducing them is equivalent to using lane 0 alone.
    assign ret_valid = &lane_valid;
    assign o_state   = out_q;

    // ------------------------------------------------------------------
    // Lanes
    // ------------------------------------------------------------------
    generate
        for (genvar j = 0; j < N_SBOX; j++) begin : g_lane
            logic [NB_BYTE-1:0] issue_byte;
            logic [NB_BYTE-1:0] lane_in;
            logic [NB_BYTE-1:0] lane_out;
            logic [NB_BYTE-1:0] fwd_byte;

            assign issue_byte = in_q[issue_cnt][j];

`ifdef AES_SUB_BYTES_INV_EN
            logic [NB_BYTE-1:0] inv_aff_byte;

            sbox_affine_transform #(
                .INVERSE(1'b1)
            ) u_inv_affine (
                .i_byte(issue_byte),
                .o_byte(inv_aff_byte)
            );

            assign lane_in = inv_q ? inv_aff_byte : issue_byte;
`else
            assign lane_in = issue_byte;
`endif

            multiplicative_inversion #(
                .OUTPUT_REG(INV_LATENCY > 2)
            ) u_inversion (
                .i_clock(i_clock),
                .i_reset(i_reset),
                .i_valid(lane_issue),
                .i_data (lane_in),
                .o_valid(lane_valid[j]),
                .o_data (lane_out)
            );

            sbox_affine_transform #(
                .INVERSE(1'b0)
            ) u_fwd_affine (
                .i_byte(lane_out),
                .o_byte(fwd_byte)
            );

`ifdef AES_SUB_BYTES_INV_EN
            assign ret_bytes[j] = inv_q ? lane_out : fwd_byte;
`else
            assign ret_bytes[j] = fwd_byte;
`endif
        end
    endgenerate

endmodule

// File: doc/aes_sub_bytes_folded.md
Name: aes_sub_bytes_folded

Overview:
- Folded AES SubBytes stage: accepts one 128-bit state, streams it through N_SBOX GF(2^8) inversion lanes (the team's multiplicative_inversion block, output register disabled, 2-cycle latency) and applies the affine transform to each returned byte.
- Reassembles the 16 results and presents the substituted state with a valid/ready handshake.
- Sits between AddRoundKey and ShiftRows in the GCM-AES core.

Parameters:
- NB_BYTE, 8, byte width; only 8 is supported.
- N_BYTES, 16, bytes per state.
- N_SBOX, 4, parallel inversion lanes; must divide N_BYTES.
- INV_LATENCY, 2, inversion lane latency in cycles; must match the instantiated lane configuration.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high; clock i_clock.
- i_state  in  NB_BYTE*N_BYTES  input state; byte b = i_state[8b+7:8b].
- i_valid  in  1  input state valid.
- o_ready  out  1  block can accept a state.
- o_state  out  NB_BYTE*N_BYTES  substituted state, same byte order as i_state.
- o_valid  out  1  o_state valid.
- i_ready  in  1  downstream accepts o_state.

Behaviour:
- N_SLICES = N_BYTES/N_SBOX. Slice k = bytes k*N_SBOX .. k*N_SBOX+N_SBOX-1; lane j carries byte k*N_SBOX+j.
- Reset values: o_valid=0, o_state=0, FSM=IDLE, issue/return counters=0. Lanes are reset so in-flight valids are cleared.
- FSM states:
  - IDLE: o_ready=1. On i_valid&o_ready, register i_state, clear the counters, go to ISSUE.
  - ISSUE: each cycle, drive slice issue_cnt into the lanes with lane i_valid=1 and increment issue_cnt. After slice N_SLICES-1, go to DRAIN. Lane i_valid=0 in every other state.
  - DRAIN: wait for the outstanding returns. When the last slice is written, go to DONE.
  - DONE: o_valid=1 and o_state stable. On i_ready, drop o_valid and go to IDLE.
- o_ready=1 only in IDLE; accepting is illegal in any other state, and i_valid outside IDLE is ignored.
- Return path:
  - Each lane o_valid (lane 0 is authoritative) writes affine(lane output) into o_state slice ret_cnt on the next edge, then increments ret_cnt.
  - Affine transform: s_i = b_i ^ b_(i+4)%8 ^ b_(i+5)%8 ^ b_(i+6)%8 ^ b_(i+7)%8 ^ c_i, with c = 0x63.
  - inv(0x00) = 0x00, so S(0x00) = 0x63.
- Latency: accept edge E0 → o_valid high after edge E(N_SLICES+INV_LATENCY); that is 6 cycles at defaults.
- Minimum spacing between accepts: N_SLICES+INV_LATENCY+2 cycles (8 at defaults), with i_ready held high.
- Backpressure: with i_ready=0, hold DONE indefinitely; o_state must not change.
- Simultaneous i_valid with o_valid&i_ready in DONE: the new state is not accepted that cycle; it is accepted in IDLE on the next cycle.
- Reset mid-operation (any state): next cycle is IDLE with o_valid=0 and o_state=0. Partial results are discarded and no late lane return may write o_state.
- N_SBOX=N_BYTES: N_SLICES=1, ISSUE lasts one cycle.

Optional Feature:
- Macro: AES_SUB_BYTES_INV_EN.
- Defined:
  - Adds port i_inv (in, 1), registered on accept with the state.
  - When the registered bit is 1, each byte first gets the inverse affine transform: b_i = a_(i+2)%8 ^ a_(i+5)%8 ^ a_(i+7)%8 ^ d_i, d = 0x05. The result feeds the lanes and the forward affine is bypassed on return (InvSubBytes).
  - Latency is unchanged; the inverse affine is combinational on the issue path.
- Undefined: no i_inv port; forward SubBytes only.

Decomposition:
- Shared package aes_pkg:
  - NB_BYTE, N_BYTES_BLOCK=16.
  - AES_AFFINE_C=8'h63, AES_INV_AFFINE_C=8'h05.
  - FSM state typedef/localparams (IDLE, ISSUE, DRAIN, DONE).
- One sub-module: sbox_affine_transform. Combinational, byte in/out, parameter INVERSE selects forward or inverse map. One instance per lane on the return path (and on the issue path when the macro is defined).

Test Plan:
- All bytes 0x00, then all 0x01 → o_state all 0x63, then all 0x7C; o_valid rises exactly 6 cycles after each accept.
- FIPS-197 round-1 state 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 (byte0 first) → d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
- Bytes 0x53 and 0xFF mixed into one state, with i_ready held low 10 cycles → outputs 0xED and 0x16; o_state stable and o_ready=0 throughout; the block accepts again one cycle after the i_ready handshake.
- Assert i_reset during DRAIN → o_valid=0 and o_state=0 next cycle; the following block (all 0x01) yields all 0x7C with no stale slices.
- Back-to-back blocks with i_valid held high → accepts exactly 8 cycles apart; i_valid outside IDLE is ignored.
- With AES_SUB_BYTES_INV_EN and i_inv=1: all 0x63 → all 0x00; state d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 → the original round-1 state.
